// File: rtl/riot_6532p.sv
// riot_6532p: RAM / I/O / timer combination chip (6532-style).
// Byte-wide RAM, up to four 8-bit ports with data direction registers,
// an interval timer with selectable prescaler and an active-low interrupt.
// Optional feature macro: RIOT_PA7_EDGE_EN builds the PA7 edge-detect
// interrupt; without it the PA7 flag reads 0 and edge-control writes are
// ignored.
module riot_6532p #(
  parameter int RAM_AW = 7,
  parameter int NPORTS = 2,
  parameter int TMR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs1,
  input  logic                  cs2_n,
  input  logic                  rs_n,
  input  logic                  we_n,
  input  logic [RAM_AW-1:0]     A,
  input  logic [7:0]            DI,
  output logic [7:0]            DO,
  output logic                  OE,
  input  logic [8*NPORTS-1:0]   PI,
  output logic [8*NPORTS-1:0]   PO,
  output logic [8*NPORTS-1:0]   DDR,
  output logic                  irq_n
);

  localparam int RAM_DEPTH = 1 << RAM_AW;
  localparam logic [TMR_W-1:0] CNT_ONE = 1;

  // ------------------------------------------------------------------
  // Access decode
  // ------------------------------------------------------------------
  logic w_sel;
  logic w_ram_wr;
  logic w_io_wr;
  logic w_tmr_wr;
  logic w_tmr_rd;

  assign w_sel    = cs1 & ~cs2_n;
  assign w_ram_wr = w_sel & ~rs_n & ~we_n;
  assign w_io_wr  = w_sel &  rs_n & ~A[4] & ~we_n;
  assign w_tmr_wr = w_sel &  rs_n &  A[4] &  A[2] & ~we_n;
  assign w_tmr_rd = w_sel &  rs_n &  A[4] & ~A[0] &  we_n;

  // ------------------------------------------------------------------
  // RAM: contents survive reset, read is combinational
  // ------------------------------------------------------------------
  logic [7:0] r_ram [RAM_DEPTH];

  // Store a byte on a selected RAM write
  always_ff @(posedge clk) begin
    if (w_ram_wr) begin
      r_ram[A] <= DI;
    end
  end

  // ------------------------------------------------------------------
  // Port input synchroniser; feeds both readback and PA7 edge detection
  // ------------------------------------------------------------------
  logic [8*NPORTS-1:0] r_pi_sync;

  // Sample the pins once; deliberately not reset so no false PA7 edge
  // appears when reset is released
  always_ff @(posedge clk) begin
    r_pi_sync <= PI;
  end

  // ------------------------------------------------------------------
  // I/O ports. Readback is padded to four entries so unbuilt ports read 0.
  // ------------------------------------------------------------------
  logic [7:0] w_or_rd  [4];
  logic [7:0] w_ddr_rd [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_port
      if (gi < NPORTS) begin : g_on
        logic [7:0] r_po;
        logic [7:0] r_ddr;

        // Output and direction registers for this port
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            r_po  <= 8'h00;
            r_ddr <= 8'h00;
          end else if (w_io_wr && (A[2:1] == 2'(gi))) begin
            if (A[0]) begin
              r_ddr <= DI;
            end else begin
              r_po <= DI;
            end
          end
        end

        // Output bits reflect the register, input bits reflect the pins
        assign w_or_rd[gi]       = (r_po & r_ddr) | (r_pi_sync[8*gi +: 8] & ~r_ddr);
        assign w_ddr_rd[gi]      = r_ddr;
        assign PO[8*gi +: 8]     = r_po;
        assign DDR[8*gi +: 8]    = r_ddr;
      end else begin : g_off
        assign w_or_rd[gi]  = 8'h00;
        assign w_ddr_rd[gi] = 8'h00;
      end
    end
  endgenerate

  // ------------------------------------------------------------------
  // Interval timer
  // ------------------------------------------------------------------
  logic [TMR_W-1:0] r_cnt;
  logic [9:0]       r_pre;
  logic [1:0]       r_psel;
  logic             r_tflag;
  logic             r_tie;
  logic             r_fast;
  logic             w_dec;
  logic             w_uflow;

  // Prescale reload value (P-1) for P = 1 / 8 / 64 / 1024
  function automatic logic [9:0] pre_load(input logic [1:0] s);
    case (s)
      2'd0:    pre_load = 10'd0;
      2'd1:    pre_load = 10'd7;
      2'd2:    pre_load = 10'd63;
      default: pre_load = 10'd1023;
    endcase
  endfunction

  // After the first underflow the counter runs at the clock rate
  assign w_dec   = r_fast | (r_pre == 10'd0);
  // A timer write in the same cycle masks the underflow
  assign w_uflow = ~w_tmr_wr & w_dec & (r_cnt == '0);

  // Counter and prescaler: load on write, otherwise count down
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_pre  <= 10'd0;
      r_psel <= 2'd0;
    end else if (w_tmr_wr) begin
      r_cnt  <= TMR_W'(DI);
      r_psel <= A[1:0];
      r_pre  <= pre_load(A[1:0]);
    end else begin
      r_pre <= (r_pre == 10'd0) ? pre_load(r_psel) : (r_pre - 10'd1);
      if (w_dec) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
    end
  end

  // Timer flag, enable and fast mode; an underflow beats a clearing read
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tflag <= 1'b0;
      r_tie   <= 1'b0;
      r_fast  <= 1'b0;
    end else if (w_tmr_wr) begin
      r_tflag <= 1'b0;
      r_tie   <= A[3];
      r_fast  <= 1'b0;
    end else begin
      if (w_uflow) begin
        r_tflag <= 1'b1;
        r_fast  <= 1'b1;
      end else if (w_tmr_rd) begin
        r_tflag <= 1'b0;
      end
      if (w_tmr_rd) begin
        r_tie <= A[3];
      end
    end
  end

  // ------------------------------------------------------------------
  // PA7 edge interrupt (optional)
  // ------------------------------------------------------------------
  logic w_pa7_flag;
  logic w_pa7_irq;

`ifdef RIOT_PA7_EDGE_EN
  logic w_flg_rd;
  logic w_ectl_wr;
  logic w_pa7_evt;
  logic r_pa7_prev;
  logic r_pa7_flag;
  logic r_pa7_ie;
  logic r_pa7_pol;

  assign w_flg_rd  = w_sel & rs_n & A[4] &  A[0] &  we_n;
  assign w_ectl_wr = w_sel & rs_n & A[4] & ~A[2] & ~we_n;
  // Polarity 1 looks for a rising edge, 0 for a falling edge
  assign w_pa7_evt = r_pa7_pol ? ( r_pi_sync[7] & ~r_pa7_prev)
                               : (~r_pi_sync[7] &  r_pa7_prev);

  // Previous synchronised PA7 level for edge comparison
  always_ff @(posedge clk) begin
    r_pa7_prev <= r_pi_sync[7];
  end

  // Edge control, and the flag which a coincident edge keeps set
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pa7_flag <= 1'b0;
      r_pa7_ie   <= 1'b0;
      r_pa7_pol  <= 1'b0;
    end else begin
      if (w_pa7_evt) begin
        r_pa7_flag <= 1'b1;
      end else if (w_flg_rd) begin
        r_pa7_flag <= 1'b0;
      end
      if (w_ectl_wr) begin
        r_pa7_pol <= A[0];
        r_pa7_ie  <= A[1];
      end
    end
  end

  assign w_pa7_flag = r_pa7_flag;
  assign w_pa7_irq  = r_pa7_flag & r_pa7_ie;
`else
  assign w_pa7_flag = 1'b0;
  assign w_pa7_irq  = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Interrupt output, one cycle behind the flags
  // ------------------------------------------------------------------
  logic r_irq_n;

  // Registered interrupt request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_irq_n <= 1'b1;
    end else begin
      r_irq_n <= ~((r_tflag & r_tie) | w_pa7_irq);
    end
  end

  assign irq_n = r_irq_n;

  // ------------------------------------------------------------------
  // Read data mux; zero whenever the bus is not being read
  // ------------------------------------------------------------------
  logic [7:0] w_do;

  // Select the read source from rs_n / A
  always_comb begin
    w_do = 8'h00;
    if (w_sel && we_n) begin
      if (!rs_n) begin
        w_do = r_ram[A];
      end else if (!A[4]) begin
        w_do = A[0] ? w_ddr_rd[A[2:1]] : w_or_rd[A[2:1]];
      end else if (A[0]) begin
        w_do = {r_tflag, w_pa7_flag, 6'b000000};
      end else begin
        w_do = r_cnt[7:0];
      end
    end
  end

  assign DO = w_do;
  assign OE = w_sel & we_n;

endmodule
